// File: rtl/hpm_pkg.sv
// Shared constants, types and CSR address decode for the hardware performance monitor bank.
package hpm_pkg;

  localparam logic [11:0] HPM_MCNT_BASE  = 12'hB03;
  localparam logic [11:0] HPM_MCNTH_BASE = 12'hB83;
  localparam logic [11:0] HPM_MEVT_BASE  = 12'h323;
  localparam logic [11:0] HPM_MEVTH_BASE = 12'h723;
  localparam logic [11:0] HPM_CNT_BASE   = 12'hC03;
  localparam logic [11:0] HPM_CNTH_BASE  = 12'hC83;
  localparam int unsigned HPM_RANGE      = 29;

  // Flag positions are counted down from the top of the CSR word: bit XLEN-ofs.
  localparam int unsigned HPM_OF_OFS   = 1;
  localparam int unsigned HPM_MINH_OFS = 2;
  localparam int unsigned HPM_SINH_OFS = 3;
  localparam int unsigned HPM_UINH_OFS = 4;

  localparam int unsigned HPM_MAX_EVENTS = 64;
  localparam int unsigned HPM_SEL_W      = $clog2(HPM_MAX_EVENTS);

  localparam logic [1:0] PRIV_U = 2'd0;
  localparam logic [1:0] PRIV_S = 2'd1;
  localparam logic [1:0] PRIV_M = 2'd3;

  typedef logic [HPM_SEL_W-1:0] hpm_sel_t;

  typedef struct packed {
    logic     of;
    logic     minh;
    logic     sinh;
    logic     uinh;
    hpm_sel_t sel;
  } hpm_evt_t;

  typedef enum logic [2:0] {
    HPM_NONE, HPM_MCNT, HPM_MCNTH, HPM_MEVT, HPM_MEVTH, HPM_CNT, HPM_CNTH
  } hpm_kind_e;

  typedef struct packed {
    hpm_kind_e  kind;
    logic [4:0] idx;
  } hpm_dec_t;

  localparam logic [11:0] HPM_BASES [6] = '{
    HPM_MCNT_BASE, HPM_MCNTH_BASE, HPM_MEVT_BASE,
    HPM_MEVTH_BASE, HPM_CNT_BASE, HPM_CNTH_BASE
  };

  // Ranges never overlap, so at most one base matches.
  function automatic hpm_dec_t hpm_decode(input logic [11:0] addr);
    hpm_dec_t   d;
    logic [11:0] off;
    d.kind = HPM_NONE;
    d.idx  = '0;
    for (int k = 0; k < 6; k++) begin
      off = addr - HPM_BASES[k];
      if (off < 12'(HPM_RANGE)) begin
        d.kind = hpm_kind_e'(3'(k + 1));
        d.idx  = off[4:0];
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/hpm_counter.sv
// One performance counter with its event selector, privilege inhibits and sticky overflow flag.
module hpm_counter
  import hpm_pkg::*;
#(
  parameter int unsigned CounterWidth = 64,
  parameter int unsigned NumEvents    = 64,
  parameter int unsigned IncWidth     = 2,
  parameter int unsigned XLEN         = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          i_debug_mode,
  input  logic [1:0]                    i_priv_lvl,
  input  logic                          i_inhibit,
  input  logic [NumEvents*IncWidth-1:0] i_event_inc,
  input  logic                          i_cnt_we_lo,
  input  logic                          i_cnt_we_hi,
  input  logic                          i_evt_we_lo,
  input  logic                          i_evt_we_hi,
  input  logic [XLEN-1:0]               i_wdata,
  output logic [CounterWidth-1:0]       o_cnt,
  output hpm_evt_t                      o_evt
);

  localparam int unsigned SelW = (NumEvents > 1) ? $clog2(NumEvents) : 1;

  logic [CounterWidth-1:0] r_cnt;
  hpm_evt_t                r_evt;

  logic [IncWidth-1:0]   w_amt;
  logic                  w_mode_inh;
  logic                  w_any_we;
  logic                  w_inc_en;
  logic [CounterWidth:0] w_sum;
  logic [63:0]           w_cnt_wr;
  hpm_evt_t              w_evt_wr;

  // Event 0 and selectors past the last event never count.
  always_comb begin
    w_amt = '0;
    for (int e = 1; e < NumEvents; e++) begin
      if (r_evt.sel == hpm_sel_t'(e)) w_amt = i_event_inc[e*IncWidth +: IncWidth];
    end
  end

  always_comb begin
    w_mode_inh = 1'b0;
    case (i_priv_lvl)
      PRIV_M:  w_mode_inh = r_evt.minh;
      PRIV_S:  w_mode_inh = r_evt.sinh;
      PRIV_U:  w_mode_inh = r_evt.uinh;
      default: w_mode_inh = 1'b0;
    endcase
  end

  assign w_any_we = i_cnt_we_lo | i_cnt_we_hi | i_evt_we_lo | i_evt_we_hi;
  assign w_inc_en = !i_debug_mode && !i_inhibit && !w_mode_inh && !w_any_we;
  assign w_sum    = {1'b0, r_cnt} + (CounterWidth+1)'(w_amt);

  // A half write merges into the current value; the other half is kept.
  always_comb begin
    w_cnt_wr = 64'(r_cnt);
    if (i_cnt_we_lo) w_cnt_wr[XLEN-1:0] = i_wdata;
    if (i_cnt_we_hi) w_cnt_wr[63:32]    = i_wdata[31:0];
    w_evt_wr = r_evt;
    if (i_evt_we_lo) w_evt_wr.sel = hpm_sel_t'(i_wdata[SelW-1:0]);
    if (i_evt_we_hi || (i_evt_we_lo && XLEN == 64)) begin
      w_evt_wr.of   = i_wdata[XLEN-HPM_OF_OFS];
      w_evt_wr.minh = i_wdata[XLEN-HPM_MINH_OFS];
      w_evt_wr.sinh = i_wdata[XLEN-HPM_SINH_OFS];
      w_evt_wr.uinh = i_wdata[XLEN-HPM_UINH_OFS];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
      r_evt <= '0;
    end else begin
      if (i_cnt_we_lo || i_cnt_we_hi) r_cnt <= w_cnt_wr[CounterWidth-1:0];
      else if (w_inc_en)              r_cnt <= w_sum[CounterWidth-1:0];
      r_evt <= w_evt_wr;
      if (w_inc_en && w_sum[CounterWidth]) r_evt.of <= 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_evt = r_evt;

endmodule

// File: rtl/hpm_counter_bank.sv
// Bank of hpm counters behind the CSR access port: address decode, read mux and overflow irq.
module hpm_counter_bank
  import hpm_pkg::*;
#(
  parameter int unsigned NumCounters  = 29,
  parameter int unsigned CounterWidth = 64,
  parameter int unsigned NumEvents    = 64,
  parameter int unsigned IncWidth     = 2,
  parameter int unsigned XLEN         = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          debug_mode_i,
  input  logic [1:0]                    priv_lvl_i,
  input  logic [11:0]                   addr_i,
  input  logic                          we_i,
  input  logic [XLEN-1:0]               data_i,
  output logic [XLEN-1:0]               data_o,
  output logic                          access_ex_o,
  input  logic [NumEvents*IncWidth-1:0] event_inc_i,
  input  logic [NumCounters-1:0]        inhibit_i,
  output logic                          ovf_irq_o
);

  hpm_dec_t                w_dec;
  logic                    w_impl;
  logic                    w_is_h;
  logic                    w_ro;
  logic                    w_wr;
  logic [63:0]             w_sel_cnt;
  hpm_evt_t                w_sel_evt;
  logic [63:0]             w_rd;
  logic [CounterWidth-1:0] w_cnt [NumCounters];
  hpm_evt_t                w_evt [NumCounters];
  logic [NumCounters-1:0]  w_of;

  always_comb begin
    w_dec  = hpm_decode(addr_i);
    w_impl = (w_dec.kind != HPM_NONE) && (32'(w_dec.idx) < NumCounters);
    w_is_h = (w_dec.kind == HPM_MCNTH) || (w_dec.kind == HPM_MEVTH) || (w_dec.kind == HPM_CNTH);
    w_ro   = (w_dec.kind == HPM_CNT) || (w_dec.kind == HPM_CNTH);
  end

  // Unimplemented slots inside a counter range are silent: read 0, no trap.
  assign access_ex_o = w_impl && ((we_i && w_ro) || (w_is_h && XLEN == 64));
  assign w_wr        = we_i && w_impl && !access_ex_o;

  always_comb begin
    w_sel_cnt = '0;
    w_sel_evt = '0;
    w_rd      = '0;
    for (int i = 0; i < NumCounters; i++) begin
      if (w_dec.idx == 5'(i)) begin
        w_sel_cnt = 64'(w_cnt[i]);
        w_sel_evt = w_evt[i];
      end
    end
    if (w_impl && !(w_is_h && XLEN == 64)) begin
      case (w_dec.kind)
        HPM_MCNT, HPM_CNT:   w_rd = w_sel_cnt;
        HPM_MCNTH, HPM_CNTH: w_rd = {32'b0, w_sel_cnt[63:32]};
        HPM_MEVT, HPM_MEVTH: begin
          if (w_dec.kind == HPM_MEVT) w_rd[HPM_SEL_W-1:0] = w_sel_evt.sel;
          if (w_dec.kind == HPM_MEVTH || XLEN == 64) begin
            w_rd[XLEN-HPM_OF_OFS]   = w_sel_evt.of;
            w_rd[XLEN-HPM_MINH_OFS] = w_sel_evt.minh;
            w_rd[XLEN-HPM_SINH_OFS] = w_sel_evt.sinh;
            w_rd[XLEN-HPM_UINH_OFS] = w_sel_evt.uinh;
          end
        end
        default: w_rd = '0;
      endcase
    end
  end

  assign data_o = w_rd[XLEN-1:0];

  for (genvar g = 0; g < NumCounters; g++) begin : g_cnt
    logic w_hit;
    assign w_hit = w_wr && (w_dec.idx == 5'(g));

    hpm_counter #(
      .CounterWidth (CounterWidth),
      .NumEvents    (NumEvents),
      .IncWidth     (IncWidth),
      .XLEN         (XLEN)
    ) u_cnt (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .i_debug_mode (debug_mode_i),
      .i_priv_lvl   (priv_lvl_i),
      .i_inhibit    (inhibit_i[g]),
      .i_event_inc  (event_inc_i),
      .i_cnt_we_lo  (w_hit && w_dec.kind == HPM_MCNT),
      .i_cnt_we_hi  (w_hit && w_dec.kind == HPM_MCNTH),
      .i_evt_we_lo  (w_hit && w_dec.kind == HPM_MEVT),
      .i_evt_we_hi  (w_hit && w_dec.kind == HPM_MEVTH),
      .i_wdata      (data_i),
      .o_cnt        (w_cnt[g]),
      .o_evt        (w_evt[g])
    );

    assign w_of[g] = w_evt[g].of;
  end

  assign ovf_irq_o = |w_of;

endmodule

// File: tb/tb_hpm_counter_bank.sv
// Directed bench: three bank instances (64-bit, 16-bit counters, XLEN=32) on one clock.
module tb_hpm_counter_bank;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        debug;
  logic [1:0]  priv;
  logic [11:0] inc;
  logic [3:0]  inh;
  logic [63:0] wdata;

  logic [11:0] addr_a, addr_b, addr_c;
  logic        we_a, we_b, we_c;
  logic [63:0] do_a, do_b;
  logic [31:0] do_c;
  logic        ex_a, ex_b, ex_c, irq_a, irq_b, irq_c;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  hpm_counter_bank #(.NumCounters(4), .CounterWidth(64), .NumEvents(6), .IncWidth(2), .XLEN(64)) dut_a (
    .clk_i(clk_i), .rst_ni(rst_ni), .debug_mode_i(debug), .priv_lvl_i(priv), .addr_i(addr_a),
    .we_i(we_a), .data_i(wdata), .data_o(do_a), .access_ex_o(ex_a), .event_inc_i(inc),
    .inhibit_i(inh), .ovf_irq_o(irq_a));

  hpm_counter_bank #(.NumCounters(4), .CounterWidth(16), .NumEvents(6), .IncWidth(2), .XLEN(64)) dut_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .debug_mode_i(debug), .priv_lvl_i(priv), .addr_i(addr_b),
    .we_i(we_b), .data_i(wdata), .data_o(do_b), .access_ex_o(ex_b), .event_inc_i(inc),
    .inhibit_i(inh), .ovf_irq_o(irq_b));

  hpm_counter_bank #(.NumCounters(4), .CounterWidth(64), .NumEvents(6), .IncWidth(2), .XLEN(32)) dut_c (
    .clk_i(clk_i), .rst_ni(rst_ni), .debug_mode_i(debug), .priv_lvl_i(priv), .addr_i(addr_c),
    .we_i(we_c), .data_i(wdata[31:0]), .data_o(do_c), .access_ex_o(ex_c), .event_inc_i(inc),
    .inhibit_i(inh), .ovf_irq_o(irq_c));

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input int d, input logic [11:0] a, input logic [63:0] v);
    wdata = v;
    case (d)
      0: begin addr_a = a; we_a = 1'b1; end
      1: begin addr_b = a; we_b = 1'b1; end
      default: begin addr_c = a; we_c = 1'b1; end
    endcase
    tick();
    we_a = 1'b0; we_b = 1'b0; we_c = 1'b0;
  endtask

  task automatic rd(input int d, input logic [11:0] a);
    case (d)
      0: addr_a = a;
      1: addr_b = a;
      default: addr_c = a;
    endcase
    #1;
  endtask

  task automatic run(input logic [11:0] v, input int n);
    inc = v;
    repeat (n) tick();
    inc = '0;
  endtask

  task automatic test_reset();
    rd(0, 12'hB03); n_chk++; if (do_a !== 64'd0) begin n_err++; $display("FAIL reset_cnt: got %0h exp 0", do_a); end
    rd(0, 12'h323); n_chk++; if (do_a !== 64'd0) begin n_err++; $display("FAIL reset_evt: got %0h exp 0", do_a); end
    n_chk++; if ({irq_a, irq_b, irq_c} !== 3'b000) begin n_err++; $display("FAIL reset_irq: got %b exp 000", {irq_a, irq_b, irq_c}); end
    rd(0, 12'h000); n_chk++; if ({ex_a, do_a} !== 65'd0) begin n_err++; $display("FAIL reset_oor: ex %b data %0h exp 0/0", ex_a, do_a); end
  endtask

  task automatic test_count();
    wr(0, 12'h323, 64'd5);
    run(12'h800, 10);
    rd(0, 12'hB03); n_chk++; if (do_a !== 64'd20) begin n_err++; $display("FAIL count_m: got %0d exp 20", do_a); end
    rd(0, 12'hC03); n_chk++; if (do_a !== 64'd20 || ex_a !== 1'b0) begin n_err++; $display("FAIL count_u: got %0d ex %b exp 20/0", do_a, ex_a); end
    rd(0, 12'h323); n_chk++; if (do_a !== 64'd5) begin n_err++; $display("FAIL count_evt: got %0h exp 5", do_a); end
  endtask

  task automatic test_sel_range();
    wr(0, 12'h324, 64'd7);
    run(12'hFFF, 3);
    rd(0, 12'hB03); n_chk++; if (do_a !== 64'd29) begin n_err++; $display("FAIL sel_cnt3: got %0d exp 29", do_a); end
    rd(0, 12'hB04); n_chk++; if (do_a !== 64'd0) begin n_err++; $display("FAIL sel_oob: got %0d exp 0", do_a); end
    rd(0, 12'hB05); n_chk++; if (do_a !== 64'd0) begin n_err++; $display("FAIL sel_zero: got %0d exp 0", do_a); end
    rd(0, 12'h324); n_chk++; if (do_a !== 64'd7) begin n_err++; $display("FAIL sel_rd: got %0h exp 7", do_a); end
  endtask

  task automatic test_inhibit();
    wr(0, 12'h325, 64'h1000_0000_0000_0001);
    priv = 2'd0; run(12'h004, 5);
    rd(0, 12'hB05); n_chk++; if (do_a !== 64'd0) begin n_err++; $display("FAIL inh_uinh: got %0d exp 0", do_a); end
    priv = 2'd3; run(12'h004, 5);
    rd(0, 12'hB05); n_chk++; if (do_a !== 64'd5) begin n_err++; $display("FAIL inh_mmode: got %0d exp 5", do_a); end
    debug = 1'b1; run(12'h004, 5); debug = 1'b0;
    rd(0, 12'hB05); n_chk++; if (do_a !== 64'd5) begin n_err++; $display("FAIL inh_debug: got %0d exp 5", do_a); end
    inh = 4'b0100; run(12'h004, 5); inh = 4'b0000;
    rd(0, 12'hB05); n_chk++; if (do_a !== 64'd5) begin n_err++; $display("FAIL inh_mcinh: got %0d exp 5", do_a); end
    priv = 2'd1; run(12'h004, 2); priv = 2'd3;
    rd(0, 12'hB05); n_chk++; if (do_a !== 64'd7) begin n_err++; $display("FAIL inh_smode: got %0d exp 7", do_a); end
    rd(0, 12'h325); n_chk++; if (do_a !== 64'h1000_0000_0000_0001) begin n_err++; $display("FAIL inh_evt_rd: got %0h exp 1000000000000001", do_a); end
  endtask

  task automatic test_collision();
    wr(0, 12'hB03, 64'hFFFF_FFFF_FFFF_FFFF);
    inc = 12'hC00;
    wr(0, 12'hB03, 64'd100);
    inc = '0;
    rd(0, 12'hB03); n_chk++; if (do_a !== 64'd100) begin n_err++; $display("FAIL coll_val: got %0d exp 100", do_a); end
    n_chk++; if (irq_a !== 1'b0) begin n_err++; $display("FAIL coll_irq: got %b exp 0", irq_a); end
    wr(0, 12'hB03, 64'hFFFF_FFFF_FFFF_FFFF);
    run(12'h400, 1);
    rd(0, 12'hB03); n_chk++; if (do_a !== 64'd0) begin n_err++; $display("FAIL ovf64_wrap: got %0h exp 0", do_a); end
    n_chk++; if (irq_a !== 1'b1) begin n_err++; $display("FAIL ovf64_irq: got %b exp 1", irq_a); end
    rd(0, 12'h323); n_chk++; if (do_a !== 64'h8000_0000_0000_0005) begin n_err++; $display("FAIL ovf64_of: got %0h exp 8000000000000005", do_a); end
    wr(0, 12'h323, 64'd5);
    n_chk++; if (irq_a !== 1'b0) begin n_err++; $display("FAIL ovf64_clr: got %b exp 0", irq_a); end
  endtask

  task automatic test_access_ex();
    wr(0, 12'hB03, 64'h1234);
    addr_a = 12'hC03; we_a = 1'b1; wdata = 64'h55; #1;
    n_chk++; if (ex_a !== 1'b1) begin n_err++; $display("FAIL ex_ro_wr: got %b exp 1", ex_a); end
    tick(); we_a = 1'b0;
    rd(0, 12'hB03); n_chk++; if (do_a !== 64'h1234 || ex_a !== 1'b0) begin n_err++; $display("FAIL ex_ro_state: got %0h ex %b exp 1234/0", do_a, ex_a); end
    rd(0, 12'hB83); n_chk++; if (ex_a !== 1'b1 || do_a !== 64'd0) begin n_err++; $display("FAIL ex_h64: ex %b data %0h exp 1/0", ex_a, do_a); end
    rd(0, 12'h723); n_chk++; if (ex_a !== 1'b1) begin n_err++; $display("FAIL ex_evth64: got %b exp 1", ex_a); end
    addr_a = 12'hB07; we_a = 1'b1; wdata = 64'd123; #1;
    n_chk++; if (ex_a !== 1'b0) begin n_err++; $display("FAIL ex_unimpl_wr: got %b exp 0", ex_a); end
    tick(); we_a = 1'b0;
    rd(0, 12'hB07); n_chk++; if (do_a !== 64'd0 || ex_a !== 1'b0) begin n_err++; $display("FAIL unimpl_rd: got %0h ex %b exp 0/0", do_a, ex_a); end
    rd(0, 12'h7FF); n_chk++; if (do_a !== 64'd0 || ex_a !== 1'b0) begin n_err++; $display("FAIL oor_rd: got %0h ex %b exp 0/0", do_a, ex_a); end
  endtask

  task automatic test_ovf16();
    wr(1, 12'hB04, 64'hFFFE);
    wr(1, 12'h324, 64'd1);
    run(12'h00C, 1);
    rd(1, 12'hB04); n_chk++; if (do_b !== 64'h0001) begin n_err++; $display("FAIL ovf16_wrap: got %0h exp 1", do_b); end
    n_chk++; if (irq_b !== 1'b1) begin n_err++; $display("FAIL ovf16_irq: got %b exp 1", irq_b); end
    rd(1, 12'h324); n_chk++; if (do_b !== 64'h8000_0000_0000_0001) begin n_err++; $display("FAIL ovf16_of: got %0h exp 8000000000000001", do_b); end
    wr(1, 12'h324, 64'd1);
    n_chk++; if (irq_b !== 1'b0) begin n_err++; $display("FAIL ovf16_clr: got %b exp 0", irq_b); end
    wr(1, 12'hB04, 64'h12345);
    rd(1, 12'hB04); n_chk++; if (do_b !== 64'h2345) begin n_err++; $display("FAIL trunc16: got %0h exp 2345", do_b); end
  endtask

  task automatic test_xlen32();
    wr(2, 12'hB83, 64'h1);
    wr(2, 12'hB03, 64'hFFFF_FFFF);
    wr(2, 12'h323, 64'd2);
    run(12'h010, 1);
    rd(2, 12'hB03); n_chk++; if (do_c !== 32'h0) begin n_err++; $display("FAIL x32_lo: got %0h exp 0", do_c); end
    rd(2, 12'hB83); n_chk++; if (do_c !== 32'h2 || ex_c !== 1'b0) begin n_err++; $display("FAIL x32_hi: got %0h ex %b exp 2/0", do_c, ex_c); end
    rd(2, 12'hC83); n_chk++; if (do_c !== 32'h2) begin n_err++; $display("FAIL x32_hi_u: got %0h exp 2", do_c); end
    inc = 12'h010;
    wr(2, 12'hB03, 64'd7);
    inc = '0;
    rd(2, 12'hB03); n_chk++; if (do_c !== 32'h7) begin n_err++; $display("FAIL x32_half_lo: got %0h exp 7", do_c); end
    rd(2, 12'hB83); n_chk++; if (do_c !== 32'h2) begin n_err++; $display("FAIL x32_half_hi: got %0h exp 2", do_c); end
    wr(2, 12'h723, 64'h8000_0000);
    n_chk++; if (irq_c !== 1'b1) begin n_err++; $display("FAIL x32_sw_of: got %b exp 1", irq_c); end
    rd(2, 12'h723); n_chk++; if (do_c !== 32'h8000_0000) begin n_err++; $display("FAIL x32_evth: got %0h exp 80000000", do_c); end
    rd(2, 12'h323); n_chk++; if (do_c !== 32'h2) begin n_err++; $display("FAIL x32_evt: got %0h exp 2", do_c); end
  endtask

  task automatic test_async_reset();
    wr(0, 12'h323, 64'h8000_0000_0000_0005);
    n_chk++; if (irq_a !== 1'b1) begin n_err++; $display("FAIL arst_pre: got %b exp 1", irq_a); end
    rd(0, 12'hB03);
    #2 rst_ni = 1'b0;
    #1;
    n_chk++; if (irq_a !== 1'b0 || irq_c !== 1'b0 || do_a !== 64'd0) begin n_err++; $display("FAIL arst: irq_a %b irq_c %b cnt %0h exp 0/0/0", irq_a, irq_c, do_a); end
    #3 rst_ni = 1'b1;
    tick();
    rd(2, 12'hB83); n_chk++; if (do_c !== 32'h0) begin n_err++; $display("FAIL arst_c: got %0h exp 0", do_c); end
  endtask

  initial begin
    rst_ni = 1'b0; debug = 1'b0; priv = 2'd3; inc = '0; inh = '0; wdata = '0;
    addr_a = '0; addr_b = '0; addr_c = '0; we_a = 1'b0; we_b = 1'b0; we_c = 1'b0;
    #22 rst_ni = 1'b1;
    tick();
    test_reset();
    test_count();
    test_sel_range();
    test_inhibit();
    test_collision();
    test_access_ex();
    test_ovf16();
    test_xlen32();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
